// File: rtl/pkt_ram_writer.sv
// pkt_ram_writer: ingress writer for the packet RAM. Stores each packet of a
// valid/ready word stream contiguously in a circular buffer covering the
// whole RAM and queues one (base, length) descriptor per packet for the
// switch core, which releases the space with pkt_done.
// Optional: define PKT_WRITER_STATS_EN to add the stat_pkts/stat_drops
// saturating counters and their ports.
module pkt_ram_writer #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 10,
   parameter int unsigned MAX_PKT_WORDS = 64,
   parameter int unsigned DESC_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  pkt_valid,
   output logic [ADDR_WIDTH-1:0] pkt_base,
   output logic [ADDR_WIDTH:0]   pkt_len,
   input  logic                  pkt_done
`ifdef PKT_WRITER_STATS_EN
   ,
   output logic [31:0]           stat_pkts,
   output logic [31:0]           stat_drops
`endif
);

   localparam int unsigned LEN_W = ADDR_WIDTH + 1;
   localparam int unsigned PTR_W = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [LEN_W-1:0] RAM_WORDS = LEN_W'(1 << ADDR_WIDTH);
   localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_PKT_WORDS);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DESC_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DESC_DEPTH - 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] base;
      logic [LEN_W-1:0]      len;
   } desc_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      DROP   = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [LEN_W-1:0]      offset_q, offset_d;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [LEN_W-1:0]      used, used_d;
   desc_t                 fifo [DESC_DEPTH];
   logic [PTR_W-1:0]      rd_idx, wr_idx;
   logic [CNT_W-1:0]      count, count_d;
   desc_t                 head_c;
   logic                  accept_c;
   logic                  pop_c;
   logic                  wr_c;
   logic [ADDR_WIDTH-1:0] wr_addr_c;
   logic                  commit_c;
   logic                  drop_c;
   logic                  in_ready_d;

   assign accept_c  = in_valid & in_ready;
   assign head_c    = fifo[rd_idx];
   assign pop_c     = pkt_done & (count != '0);
   assign pkt_valid = (count != '0);
   assign pkt_base  = head_c.base;
   assign pkt_len   = head_c.len;

   // FSM state register and running word offset within the current packet
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         offset_q <= '0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
      end
   end

   // Next-state, RAM write request, commit and drop decisions
   always_comb begin
      state_d   = state_q;
      offset_d  = offset_q;
      wr_c      = 1'b0;
      wr_addr_c = wr_ptr + ADDR_WIDTH'(offset_q);
      commit_c  = 1'b0;
      drop_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               wr_c      = 1'b1;
               wr_addr_c = wr_ptr;
               offset_d  = LEN_W'(1);
               state_d   = in_last ? COMMIT : RECV;
            end
         end
         RECV: begin
            if (accept_c) begin
               if (offset_q >= MAX_LEN) begin
                  // Packet exceeds the limit; a word arriving here is never written.
                  // If it also ends the packet there is nothing left to discard.
                  drop_c  = 1'b1;
                  state_d = in_last ? IDLE : DROP;
               end else begin
                  wr_c     = 1'b1;
                  offset_d = offset_q + LEN_W'(1);
                  if (in_last) begin
                     state_d = COMMIT;
                  end
               end
            end
         end
         DROP: begin
            if (accept_c && in_last) begin
               state_d = IDLE;
            end
         end
         COMMIT: begin
            commit_c = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next reservation count, FIFO occupancy and ready for the following cycle
   always_comb begin
      used_d = used;
      if (commit_c) begin
         used_d = used_d + offset_q;
      end
      if (pop_c) begin
         used_d = used_d - head_c.len;
      end
      count_d = count;
      if (commit_c && !pop_c) begin
         count_d = count + CNT_W'(1);
      end else if (!commit_c && pop_c) begin
         count_d = count - CNT_W'(1);
      end
      if (state_d == IDLE) begin
         in_ready_d = ((RAM_WORDS - used_d) >= MAX_LEN) && (count_d != FIFO_FULL);
      end else if (state_d == COMMIT) begin
         in_ready_d = 1'b0;
      end else begin
         in_ready_d = 1'b1;
      end
   end

   // Write pointer, space accounting and descriptor FIFO
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         used   <= '0;
         count  <= '0;
         rd_idx <= '0;
         wr_idx <= '0;
         for (int i = 0; i < int'(DESC_DEPTH); i++) begin
            fifo[PTR_W'(i)] <= '0;
         end
      end else begin
         used  <= used_d;
         count <= count_d;
         if (commit_c) begin
            fifo[wr_idx] <= '{base: wr_ptr, len: offset_q};
            wr_idx       <= (wr_idx == PTR_LAST) ? '0 : wr_idx + PTR_W'(1);
            wr_ptr       <= wr_ptr + ADDR_WIDTH'(offset_q);
         end
         if (pop_c) begin
            rd_idx <= (rd_idx == PTR_LAST) ? '0 : rd_idx + PTR_W'(1);
         end
      end
   end

   // Registered RAM write port and stream ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
         in_ready <= 1'b0;
      end else begin
         ram_we   <= wr_c;
         in_ready <= in_ready_d;
         if (wr_c) begin
            ram_addr <= wr_addr_c;
            ram_data <= in_data;
         end
      end
   end

`ifdef PKT_WRITER_STATS_EN
   // Saturating counters of committed and dropped packets
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_pkts  <= '0;
         stat_drops <= '0;
      end else begin
         if (commit_c && (stat_pkts != '1)) begin
            stat_pkts <= stat_pkts + 32'd1;
         end
         if (drop_c && (stat_drops != '1)) begin
            stat_drops <= stat_drops + 32'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pkt_ram_writer.sv
// Directed bench for pkt_ram_writer with ADDR_WIDTH=4, MAX_PKT_WORDS=8,
// DESC_DEPTH=2. RAM writes are logged on the falling edge and compared with
// hand-computed addresses and data.
module tb_pkt_ram_writer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        ram_we;
   logic [3:0]  ram_addr;
   logic [31:0] ram_data;
   logic        pkt_valid;
   logic [3:0]  pkt_base;
   logic [4:0]  pkt_len;
   logic        pkt_done;
`ifdef PKT_WRITER_STATS_EN
   logic [31:0] stat_pkts;
   logic [31:0] stat_drops;
`endif

   int checks   = 0;
   int failures = 0;

   logic [3:0]  la [$];
   logic [31:0] ld [$];

   pkt_ram_writer #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (4),
      .MAX_PKT_WORDS(8),
      .DESC_DEPTH   (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .pkt_valid(pkt_valid),
      .pkt_base (pkt_base),
      .pkt_len  (pkt_len),
      .pkt_done (pkt_done)
`ifdef PKT_WRITER_STATS_EN
      ,
      .stat_pkts (stat_pkts),
      .stat_drops(stat_drops)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every RAM write once per cycle
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         la.push_back(ram_addr);
         ld.push_back(ram_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (in_ready !== 1'b1 && n < 50) begin
         step(1);
         n++;
      end
      check("send_ready", 64'(in_ready), 64'(1));
      step(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] tag, input int n);
      for (int i = 0; i < n; i++) begin
         send(tag + 32'(i), (i == n - 1));
      end
   endtask

   task automatic release_head();
      pkt_done = 1'b1;
      step(1);
      pkt_done = 1'b0;
   endtask

   task automatic check_desc(input string tag, input logic [3:0] base, input logic [4:0] len);
      check({tag, "_valid"}, 64'(pkt_valid), 64'(1));
      check({tag, "_base"}, 64'(pkt_base), 64'(base));
      check({tag, "_len"}, 64'(pkt_len), 64'(len));
   endtask

   task automatic check_log(input string tag, input int n, input logic [3:0] a0, input logic [31:0] d0);
      check({tag, "_wcount"}, 64'(la.size()), 64'(n));
      for (int i = 0; i < n && i < la.size(); i++) begin
         logic [3:0] ea;
         ea = a0 + 4'(i);
         check({tag, "_waddr"}, 64'(la[i]), 64'(ea));
         check({tag, "_wdata"}, 64'(ld[i]), 64'(d0 + 32'(i)));
      end
   endtask

   task automatic clear_log();
      la.delete();
      ld.delete();
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      pkt_done = 1'b0;

      // Reset state
      step(2);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_ram_we", 64'(ram_we), 64'(0));
      check("rst_pkt_valid", 64'(pkt_valid), 64'(0));
      check("rst_pkt_len", 64'(pkt_len), 64'(0));
      rst = 1'b1;
      step(1);
      check("idle_in_ready", 64'(in_ready), 64'(1));

      // Single 3-word packet
      clear_log();
      send_pkt(32'hA0, 3);
      check("commit_in_ready", 64'(in_ready), 64'(0));
      check("commit_no_desc", 64'(pkt_valid), 64'(0));
      step(1);
      check_desc("single", 4'd0, 5'd3);
      check("single_ready_back", 64'(in_ready), 64'(1));
      check("single_we_off", 64'(ram_we), 64'(0));
      check_log("single", 3, 4'd0, 32'hA0);
      release_head();
      check("single_released", 64'(pkt_valid), 64'(0));

      // Asynchronous reset on the second word of a packet
      send(32'hEE, 1'b0);
      check("pre_rst_we", 64'(ram_we), 64'(1));
      check("pre_rst_addr", 64'(ram_addr), 64'(3));
      in_valid = 1'b1;
      in_data  = 32'hEF;
      rst      = 1'b0;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'(0));
      check("mid_rst_ram_we", 64'(ram_we), 64'(0));
      check("mid_rst_ram_addr", 64'(ram_addr), 64'(0));
      check("mid_rst_ram_data", 64'(ram_data), 64'(0));
      check("mid_rst_pkt_valid", 64'(pkt_valid), 64'(0));
      check("mid_rst_pkt_base", 64'(pkt_base), 64'(0));
      in_valid = 1'b0;
      step(1);
      rst = 1'b1;
      step(1);
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
      check("post_rst_no_desc", 64'(pkt_valid), 64'(0));

      // Wrap: 6 + 8 words released, then 4 words straddle the top
      send_pkt(32'hB0, 6);
      step(1);
      check_desc("p6", 4'd0, 5'd6);
      release_head();
      send_pkt(32'hC0, 8);
      step(1);
      check_desc("p8", 4'd6, 5'd8);
      release_head();
      clear_log();
      send_pkt(32'hD0, 4);
      step(1);
      check_desc("wrap", 4'd14, 5'd4);
      check_log("wrap", 4, 4'd14, 32'hD0);
      release_head();

      // Backpressure: two unreleased packets fill the descriptor FIFO
      send_pkt(32'h100, 4);
      send_pkt(32'h200, 4);
      step(1);
      check("full_in_ready", 64'(in_ready), 64'(0));
      check_desc("full_head", 4'd2, 5'd4);
      step(3);
      check("full_in_ready_hold", 64'(in_ready), 64'(0));
      release_head();
      check("pop_in_ready", 64'(in_ready), 64'(1));
      check_desc("pop_head", 4'd6, 5'd4);
      release_head();
      check("bp_empty", 64'(pkt_valid), 64'(0));

      // Oversize: 10 words, only 8 written, no descriptor
      clear_log();
      send_pkt(32'h50, 10);
      check("over_no_desc", 64'(pkt_valid), 64'(0));
      check("over_in_ready", 64'(in_ready), 64'(1));
      check_log("over", 8, 4'd10, 32'h50);
`ifdef PKT_WRITER_STATS_EN
      check("stat_drops", 64'(stat_drops), 64'(1));
`endif
      send_pkt(32'h60, 2);
      step(1);
      check_desc("after_over", 4'd10, 5'd2);
`ifdef PKT_WRITER_STATS_EN
      check("stat_pkts", 64'(stat_pkts), 64'(6));
`endif
      release_head();

      // Pop of a 3-word head in the same cycle as a 5-word commit
      send_pkt(32'h70, 3);
      step(1);
      check_desc("head3", 4'd12, 5'd3);
      clear_log();
      send_pkt(32'h80, 5);
      pkt_done = 1'b1;
      step(1);
      pkt_done = 1'b0;
      check_desc("simul", 4'd15, 5'd5);
      check_log("simul", 5, 4'd15, 32'h80);
      release_head();
      check("simul_count", 64'(pkt_valid), 64'(0));

      // Space must be fully returned: a 6-word packet leaves room for another
      send_pkt(32'h90, 6);
      step(1);
      check_desc("space", 4'd4, 5'd6);
      check("space_in_ready", 64'(in_ready), 64'(1));
      release_head();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
